// File: rtl/simon_key_schedule.sv
// SIMON 64/128 and 128/128 round-key generator; streams keys to simon_round over a valid/ready handshake.
// Optional: define SIMON_KS_DECRYPT_EN to add the key buffer that serves keys in reverse (decrypt) order.
`ifndef SIMON_MODE_64_128
`define SIMON_MODE_64_128 1'b0
`endif
`ifndef SIMON_MODE_128_128
`define SIMON_MODE_128_128 1'b1
`endif

module simon_key_schedule #(
  parameter int SIMON_MAX_WORD_WIDTH = 64
) (
  input  logic                            ck,
  input  logic                            nrst,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            enc_dec,
  input  logic [127:0]                    key_in,
  output logic [SIMON_MAX_WORD_WIDTH-1:0] key_out,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int W     = SIMON_MAX_WORD_WIDTH;
  localparam int T_MAX = 68;

  localparam logic [6:0] LAST_64  = 7'd43;
  localparam logic [6:0] LAST_128 = 7'd67;

  // Bit 61 holds z[0] (leftmost character of the published sequence).
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

`ifdef SIMON_KS_DECRYPT_EN
  localparam bit DECRYPT_EN = 1'b1;
`else
  localparam bit DECRYPT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;
  typedef logic [W-1:0] word_t;

  localparam word_t ROUND_C3 = W'(3);

  state_t     state;
  logic       is128;
  logic       enc;
  logic [6:0] cnt;
  word_t      win [4];

  word_t      load_win  [4];
  word_t      shift_win [4];
  word_t      tmp;
  word_t      new_word;
  word_t      word_mask;
  logic [6:0] last_idx;
  logic [5:0] z_idx;
  logic       z_bit;
  logic       load_128;
  logic       last_key;

  // Rotate right within the active word size; the 32-bit result is zero-extended.
  function automatic word_t rotr(input word_t x, input int unsigned r, input logic wide);
    logic [31:0] lo;
    lo = x[31:0];
    if (wide) return (x >> r) | (x << (W - r));
    return word_t'((lo >> r) | (lo << (32 - r)));
  endfunction

  // Master-key split into the initial sliding window k[0..m-1].
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    load_128 = (mode == `SIMON_MODE_128_128);
    for (int j = 0; j < 4; j++) load_win[j] = word_t'(key_in[32*j +: 32]);
    if (load_128) begin
      load_win[0] = word_t'(key_in[63:0]);
      load_win[1] = word_t'(key_in[127:64]);
      load_win[2] = '0;
      load_win[3] = '0;
    end
  end

  // Next key k[cnt+m] from the window whose head is k[cnt].
  always_comb begin
    last_idx  = is128 ? LAST_128 : LAST_64;
    word_mask = is128 ? '1 : word_t'(32'hffff_ffff);
    z_idx     = (cnt >= 7'd62) ? 6'(cnt - 7'd62) : cnt[5:0];
    z_bit     = is128 ? Z2[6'd61 - z_idx] : Z3[6'd61 - z_idx];
    tmp       = is128 ? rotr(win[1], 3, 1'b1) : (rotr(win[3], 3, 1'b0) ^ win[1]);
    new_word  = (~win[0] ^ tmp ^ rotr(tmp, 1, is128) ^ ROUND_C3 ^ word_t'(z_bit)) & word_mask;

    shift_win[0] = win[1];
    shift_win[1] = is128 ? new_word : win[2];
    shift_win[2] = win[3];
    shift_win[3] = new_word;

    last_key = enc ? (cnt == last_idx) : (cnt == 7'd0);
  end

`ifdef SIMON_KS_DECRYPT_EN
  word_t key_buf [T_MAX];

  // NOTE: the key buffer has no reset; every entry is written during EXPAND before STREAM reads it.
  always_ff @(posedge ck) begin
    if (state == EXPAND) key_buf[cnt] <= win[0];
  end
`endif

  always_ff @(posedge ck) begin
    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    if (!nrst) begin
      state     <= IDLE;
      is128     <= 1'b0;
      enc       <= 1'b1;
      cnt       <= '0;
      for (int j = 0; j < 4; j++) win[j] <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (enc_dec || DECRYPT_EN) begin
              is128 <= load_128;
              enc   <= enc_dec;
              cnt   <= '0;
              win   <= load_win;
              busy  <= 1'b1;
              if (enc_dec) begin
                state     <= STREAM;
                key_out   <= load_win[0];
                key_valid <= 1'b1;
              end else begin
                state <= EXPAND;
              end
            end else begin
              error <= 1'b1;
            end
          end
        end

        EXPAND: begin
`ifdef SIMON_KS_DECRYPT_EN
          win <= shift_win;
          if (cnt == last_idx) begin
            // k[T-1] is bypassed straight from the window while it is being stored.
            state     <= STREAM;
            key_out   <= win[0];
            key_valid <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        STREAM: begin
          if (key_ready) begin
            if (last_key) begin
              state     <= IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (enc) begin
              cnt     <= cnt + 7'd1;
              win     <= shift_win;
              key_out <= win[1];
            end else begin
`ifdef SIMON_KS_DECRYPT_EN
              cnt     <= cnt - 7'd1;
              key_out <= key_buf[cnt - 7'd1];
`endif
            end
          end
        end

        default: begin
          state     <= IDLE;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: published SIMON vectors, stalls, reset and start-while-busy.
`ifndef SIMON_MODE_64_128
`define SIMON_MODE_64_128 1'b0
`endif
`ifndef SIMON_MODE_128_128
`define SIMON_MODE_128_128 1'b1
`endif

module tb_simon_key_schedule;

  logic         ck = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         enc_dec = 1'b1;
  logic [127:0] key_in = '0;
  logic [63:0]  key_out;
  logic         key_valid;
  logic         key_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         error;

  int cmp_count = 0;
  int mis_count = 0;

  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  localparam logic [127:0] KEY64  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] KEY128 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT64   = {64'h0, 64'h656b696c_20646e75};
  localparam logic [127:0] CT64   = {64'h0, 64'h44c8fc20_b9dfa07a};
  localparam logic [127:0] PT128  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] CT128  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

  logic [63:0] model_k [68];
  logic [63:0] got     [68];
  int          n_got;
  int          n_valid;
  int          first_valid_cyc;
  bit          saw_done;

  simon_key_schedule dut (
    .ck        (ck),
    .nrst      (nrst),
    .start     (start),
    .mode      (mode),
    .enc_dec   (enc_dec),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [63:0] rr(input logic [63:0] x, input int r, input int n);
    logic [31:0] lo;
    lo = x[31:0];
    if (n == 64) return (x >> r) | (x << (64 - r));
    return {32'h0, (lo >> r) | (lo << (32 - r))};
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input int r, input int n);
    logic [31:0] lo;
    lo = x[31:0];
    if (n == 64) return (x << r) | (x >> (64 - r));
    return {32'h0, (lo << r) | (lo >> (32 - r))};
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] x, input int n);
    return (rl(x, 1, n) & rl(x, 8, n)) ^ rl(x, 2, n);
  endfunction

  // Reference SIMON round function driven by the collected keys (inv = decryption rounds).
  function automatic logic [127:0] run_cipher(input logic [127:0] blk, input bit is128, input bit inv, input int t);
    logic [63:0] x, y, tmp;
    int n;
    n = is128 ? 64 : 32;
    x = is128 ? blk[127:64] : {32'h0, blk[63:32]};
    y = is128 ? blk[63:0]   : {32'h0, blk[31:0]};
    for (int i = 0; i < t; i++) begin
      if (!inv) begin
        tmp = x; x = y ^ fr(x, n) ^ got[i]; y = tmp;
      end else begin
        tmp = y; y = x ^ fr(y, n) ^ got[i]; x = tmp;
      end
    end
    return is128 ? {x, y} : {64'h0, x[31:0], y[31:0]};
  endfunction

  task automatic build_model(input bit is128, input logic [127:0] key);
    int m, t, n;
    logic [63:0] tmp, msk;
    logic zb;
    n   = is128 ? 64 : 32;
    m   = is128 ? 2 : 4;
    t   = is128 ? 68 : 44;
    msk = is128 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    for (int j = 0; j < m; j++)
      model_k[j] = is128 ? key[64*j +: 64] : {32'h0, key[32*j +: 32]};
    for (int i = m; i < t; i++) begin
      tmp = rr(model_k[i-1], 3, n);
      if (!is128) tmp ^= model_k[i-3];
      tmp ^= rr(tmp, 1, n);
      zb = is128 ? Z2[61 - ((i - m) % 62)] : Z3[61 - ((i - m) % 62)];
      model_k[i] = (~model_k[i-m] ^ tmp ^ 64'd3 ^ {63'd0, zb}) & msk;
    end
  endtask

  // Returns at the falling edge of the first cycle after start was sampled.
  task automatic start_sched(input bit m128, input bit enc, input logic [127:0] key);
    @(negedge ck);
    start   = 1'b1;
    mode    = m128 ? `SIMON_MODE_128_128 : `SIMON_MODE_64_128;
    enc_dec = enc;
    key_in  = key;
    @(negedge ck);
    start = 1'b0;
  endtask

  task automatic collect(input bit rnd, input bit poke, input int budget);
    logic [63:0] prev_key;
    bit stalled;
    int last_acc;
    n_got = 0; n_valid = 0; first_valid_cyc = -1; saw_done = 0;
    stalled = 0; last_acc = -10; prev_key = '0;
    for (int i = 0; i < 68; i++) got[i] = '0;
    for (int cyc = 1; cyc <= budget && !saw_done; cyc++) begin
      if (done) begin
        saw_done = 1;
        cmp_count++;
        if (last_acc !== cyc - 1) begin
          mis_count++; $display("FAIL done_timing cycle %0d last_accept %0d", cyc, last_acc);
        end
        cmp_count++;
        if (key_valid !== 1'b0) begin
          mis_count++; $display("FAIL valid_at_done got %b want 0", key_valid);
        end
      end else begin
        key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke) begin
          start = (cyc % 7 == 3);
          if (start) begin
            mode = ~mode; enc_dec = ~enc_dec; key_in = {4{$urandom}};
          end
          cmp_count++;
          if (error !== 1'b0) begin
            mis_count++; $display("FAIL busy_start_error cycle %0d got %b want 0", cyc, error);
          end
        end
        if (key_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (key_valid) n_valid++;
        if (stalled) begin
          cmp_count++;
          if ({key_valid, key_out} !== {1'b1, prev_key}) begin
            mis_count++;
            $display("FAIL stall_hold cycle %0d got %b/%h want 1/%h", cyc, key_valid, key_out, prev_key);
          end
        end
        if (key_valid && key_ready) begin
          if (n_got < 68) got[n_got] = key_out;
          n_got++;
          last_acc = cyc;
        end
        stalled  = key_valid && !key_ready;
        prev_key = key_out;
        @(negedge ck);
      end
    end
    start = 1'b0;
    key_ready = 1'b1;
    cmp_count++;
    if (saw_done !== 1'b1) begin
      mis_count++; $display("FAIL done_timeout got no done within %0d cycles", budget);
    end
    if (saw_done) begin
      @(negedge ck);
      cmp_count++;
      if ({done, busy, key_valid} !== 3'b000) begin
        mis_count++; $display("FAIL after_done got done/busy/valid %b want 000", {done, busy, key_valid});
      end
    end
  endtask

  task automatic check_keys(input string tag, input int t, input bit reversed);
    cmp_count++;
    if (n_got !== t) begin
      mis_count++; $display("FAIL %s_key_count got %0d want %0d", tag, n_got, t);
    end
    for (int i = 0; i < t; i++) begin
      cmp_count++;
      if (got[i] !== model_k[reversed ? t - 1 - i : i]) begin
        mis_count++;
        $display("FAIL %s_key[%0d] got %h want %h", tag, i, got[i], model_k[reversed ? t - 1 - i : i]);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; key_ready = 1'b1;
    repeat (2) @(negedge ck);
    cmp_count++;
    if ({key_out, key_valid, busy, done, error} !== 68'h0) begin
      mis_count++;
      $display("FAIL reset_outputs got key %h valid %b busy %b done %b error %b want all 0",
               key_out, key_valid, busy, done, error);
    end
    nrst = 1'b1;
  endtask

  task automatic test_enc_64();
    logic [255:0] head;
    build_model(1'b0, KEY64);
    key_ready = 1'b1;
    start_sched(1'b0, 1'b1, KEY64);
    collect(1'b0, 1'b0, 200);
    cmp_count++;
    if (first_valid_cyc !== 1) begin
      mis_count++; $display("FAIL enc64_latency got %0d want 1", first_valid_cyc);
    end
    cmp_count++;
    if (n_valid !== 44) begin
      mis_count++; $display("FAIL enc64_valid_cycles got %0d want 44", n_valid);
    end
    head = {got[0], got[1], got[2], got[3]};
    cmp_count++;
    if (head !== {64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918}) begin
      mis_count++; $display("FAIL enc64_first_keys got %h want 03020100/0b0a0908/13121110/1b1a1918", head);
    end
    check_keys("enc64", 44, 1'b0);
    cmp_count++;
    if (run_cipher(PT64, 1'b0, 1'b0, 44) !== CT64) begin
      mis_count++; $display("FAIL enc64_cipher got %h want %h", run_cipher(PT64, 1'b0, 1'b0, 44), CT64);
    end
  endtask

  task automatic test_enc_128();
    build_model(1'b1, KEY128);
    start_sched(1'b1, 1'b1, KEY128);
    collect(1'b0, 1'b0, 300);
    cmp_count++;
    if ({got[0], got[1]} !== {64'h0706050403020100, 64'h0f0e0d0c0b0a0908}) begin
      mis_count++; $display("FAIL enc128_first_keys got %h %h", got[0], got[1]);
    end
    cmp_count++;
    if (n_valid !== 68) begin
      mis_count++; $display("FAIL enc128_valid_cycles got %0d want 68", n_valid);
    end
    check_keys("enc128", 68, 1'b0);
    cmp_count++;
    if (run_cipher(PT128, 1'b1, 1'b0, 68) !== CT128) begin
      mis_count++; $display("FAIL enc128_cipher got %h want %h", run_cipher(PT128, 1'b1, 1'b0, 68), CT128);
    end
  endtask

  task automatic test_stall();
    build_model(1'b0, KEY64);
    start_sched(1'b0, 1'b1, KEY64);
    collect(1'b1, 1'b0, 600);
    check_keys("stall64", 44, 1'b0);
  endtask

  task automatic test_decrypt();
`ifdef SIMON_KS_DECRYPT_EN
    build_model(1'b0, KEY64);
    start_sched(1'b0, 1'b0, KEY64);
    collect(1'b0, 1'b0, 300);
    cmp_count++;
    if (first_valid_cyc !== 45) begin
      mis_count++; $display("FAIL dec64_latency got %0d want 45", first_valid_cyc);
    end
    cmp_count++;
    if (got[43] !== 64'h03020100) begin
      mis_count++; $display("FAIL dec64_last_key got %h want 03020100", got[43]);
    end
    check_keys("dec64", 44, 1'b1);
    cmp_count++;
    if (run_cipher(CT64, 1'b0, 1'b1, 44) !== PT64) begin
      mis_count++; $display("FAIL dec64_cipher got %h want %h", run_cipher(CT64, 1'b0, 1'b1, 44), PT64);
    end
`else
    bit seen;
    start_sched(1'b0, 1'b0, KEY64);
    cmp_count++;
    if ({error, busy, key_valid} !== 3'b100) begin
      mis_count++; $display("FAIL dec_reject got error/busy/valid %b want 100", {error, busy, key_valid});
    end
    seen = 1'b0;
    repeat (50) begin
      @(negedge ck);
      if (key_valid || busy || error) seen = 1'b1;
    end
    cmp_count++;
    if (seen !== 1'b0) begin
      mis_count++; $display("FAIL dec_reject_quiet got activity %b want 0", seen);
    end
`endif
  endtask

  task automatic test_reset_mid();
    build_model(1'b0, KEY64);
    key_ready = 1'b1;
    start_sched(1'b0, 1'b1, KEY64);
    repeat (20) @(negedge ck);
    cmp_count++;
    if ({key_valid, key_out} !== {1'b1, model_k[20]}) begin
      mis_count++; $display("FAIL mid_key20 got %b/%h want 1/%h", key_valid, key_out, model_k[20]);
    end
    nrst = 1'b0;
    @(negedge ck);
    cmp_count++;
    if ({key_out, key_valid, busy, done, error} !== 68'h0) begin
      mis_count++;
      $display("FAIL mid_reset_outputs got key %h valid %b busy %b done %b error %b want all 0",
               key_out, key_valid, busy, done, error);
    end
    nrst = 1'b1;
    build_model(1'b1, KEY128);
    start_sched(1'b1, 1'b1, KEY128);
    collect(1'b0, 1'b1, 300);
    cmp_count++;
    if (first_valid_cyc !== 1) begin
      mis_count++; $display("FAIL mid_restart_latency got %0d want 1", first_valid_cyc);
    end
    check_keys("restart128", 68, 1'b0);
  endtask

  initial begin
    test_reset();
    test_enc_64();
    test_enc_128();
    test_stall();
    test_decrypt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
